// File: rtl/apb_pkg.sv
// Shared types, default widths and address helpers for the APB completer.
`timescale 1ns/1ps
package apb_pkg;
  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } apb_cmp_state_t;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction
endpackage

// File: rtl/apb_completer_mem.sv
// Word-organised register memory: byte-strobed synchronous write, combinational read.
`timescale 1ns/1ps
module apb_completer_mem
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int NUM_WORDS  = 16,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [IDX_WIDTH-1:0]    waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [IDX_WIDTH-1:0]    raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);
  logic [DATA_WIDTH-1:0] mem_r [NUM_WORDS];

  // Clear on reset, otherwise merge strobed bytes into the addressed word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        mem_r[w] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wstrb[b]) begin
          mem_r[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[raddr];
endmodule

// File: rtl/apb_completer.sv
// APB4 completer: latches the setup phase, counts wait states and returns a
// registered one-cycle response; writes commit on the completing edge.
`timescale 1ns/1ps
module apb_completer
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int NUM_WORDS   = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CNT_WIDTH  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  apb_cmp_state_t        state_r, state_s;
  logic [CNT_WIDTH-1:0]  wait_cnt_r, wait_cnt_s;
  logic [IDX_WIDTH-1:0]  idx_r, idx_s;
  logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
  logic [STRB_WIDTH-1:0] strb_r, strb_s;
  logic                  write_r, write_s;
  logic                  err_r, err_s;
  logic                  abort_r, abort_s;
  logic [DATA_WIDTH-1:0] prdata_r, prdata_s;
  logic                  pready_r, pready_s;
  logic                  pslverr_r, pslverr_s;
  logic [DATA_WIDTH-1:0] mem_rdata_s;
  logic                  mem_we_s;
  logic                  setup_s;
  logic                  load_s;
  logic                  addr_err_s;

  assign setup_s    = psel & ~penable;
  assign addr_err_s = !is_aligned(paddr[1:0]) ||
                      ((paddr >> 2) >= ADDR_WIDTH'(NUM_WORDS));

  // Next-state, setup capture and response generation
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    abort_s    = abort_r;
    prdata_s   = '0;
    pready_s   = 1'b0;
    pslverr_s  = 1'b0;
    mem_we_s   = 1'b0;
    load_s     = 1'b0;

    case (state_r)
      IDLE: begin
        // psel with penable already high has no setup phase and is ignored
        load_s  = setup_s;
        state_s = setup_s ? ACCESS : IDLE;
      end
      ACCESS: begin
        if (!psel) begin
          abort_s   = 1'b1;
          pready_s  = 1'b1;
          pslverr_s = 1'b1;
          state_s   = DONE;
        end else if (wait_cnt_r == CNT_WIDTH'(WAIT_STATES)) begin
          pready_s  = 1'b1;
          pslverr_s = err_r;
          prdata_s  = (write_r || err_r) ? '0 : mem_rdata_s;
          state_s   = DONE;
        end else begin
          wait_cnt_s = wait_cnt_r + CNT_WIDTH'(1'b1);
        end
      end
      DONE: begin
        mem_we_s = write_r & ~err_r & ~abort_r & psel & penable;
        load_s   = setup_s;
        state_s  = setup_s ? ACCESS : IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (load_s) begin
      idx_s      = paddr[IDX_WIDTH+1:2];
      write_s    = pwrite;
      wdata_s    = pwdata;
      strb_s     = pstrb;
      err_s      = addr_err_s;
      abort_s    = 1'b0;
      wait_cnt_s = '0;
    end else begin
      idx_s   = idx_r;
      write_s = write_r;
      wdata_s = wdata_r;
      strb_s  = strb_r;
      err_s   = err_r;
    end
  end

  // State, latched transfer and registered response
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_r    <= IDLE;
      wait_cnt_r <= '0;
      idx_r      <= '0;
      wdata_r    <= '0;
      strb_r     <= '0;
      write_r    <= 1'b0;
      err_r      <= 1'b0;
      abort_r    <= 1'b0;
      prdata_r   <= '0;
      pready_r   <= 1'b0;
      pslverr_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      idx_r      <= idx_s;
      wdata_r    <= wdata_s;
      strb_r     <= strb_s;
      write_r    <= write_s;
      err_r      <= err_s;
      abort_r    <= abort_s;
      prdata_r   <= prdata_s;
      pready_r   <= pready_s;
      pslverr_r  <= pslverr_s;
    end
  end

  apb_completer_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_WORDS (NUM_WORDS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_mem (
    .clk  (pclk),
    .rst_n(presetn),
    .we   (mem_we_s),
    .waddr(idx_r),
    .wdata(wdata_r),
    .wstrb(strb_r),
    .raddr(idx_r),
    .rdata(mem_rdata_s)
  );

  assign prdata  = prdata_r;
  assign pready  = pready_r;
  assign pslverr = pslverr_r;
endmodule

// File: tb/tb_apb_completer.sv
// Bench for apb_completer: a zero-wait and a three-wait instance on one bus,
// driven from a vector table, hand sequences and random transfers.
`timescale 1ns/1ps
module tb_apb_completer;
  logic        pclk;
  logic        presetn;
  logic        psel_a, psel_b;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b;
  logic        pslverr_a, pslverr_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] model_mem [2][16];

  typedef struct {
    int          d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    bit          keep;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[$];

  apb_completer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_WORDS(16), .WAIT_STATES(0)) dut_a (
    .pclk(pclk), .presetn(presetn), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a)
  );

  apb_completer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_WORDS(16), .WAIT_STATES(3)) dut_b (
    .pclk(pclk), .presetn(presetn), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%h expected=%h", name, act, exp);
  endtask

  // Reference behaviour: aligned in-range words only, byte-merged writes.
  function automatic void model_xfer(input int d, input logic wr, input logic [31:0] addr,
                                     input logic [31:0] data, input logic [3:0] strb,
                                     output logic [31:0] rd, output logic err);
    int w;
    err = ((addr % 32'd4) != 32'd0) || ((addr / 32'd4) >= 32'd16);
    rd  = 32'h0;
    if (!err) begin
      w = int'(addr / 32'd4);
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) model_mem[d][w][8*b +: 8] = data[8*b +: 8];
      end else begin
        rd = model_mem[d][w];
      end
    end
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++) model_mem[d][w] = 32'h0;
  endfunction

  function automatic logic get_pready(input int d);
    return (d == 0) ? pready_a : pready_b;
  endfunction

  // One APB transfer; call at pclk posedge + 1. keep=1 leaves no idle cycle after it.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input bit keep,
                      output logic [31:0] rdata, output logic err, output int waits);
    int n;
    psel_a = (d == 0);
    psel_b = (d == 1);
    penable = 1'b0;
    pwrite = wr;
    paddr = addr;
    pwdata = data;
    pstrb = strb;
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr = $urandom;
    pwdata = $urandom;
    pstrb = 4'($urandom_range(0, 15));
    waits = 0;
    n = 0;
    @(negedge pclk);
    while (get_pready(d) !== 1'b1 && n < 64) begin
      waits++;
      n++;
      @(negedge pclk);
    end
    rdata = (d == 0) ? prdata_a : prdata_b;
    err   = (d == 0) ? pslverr_a : pslverr_b;
    @(posedge pclk); #1;
    check("pready_pulse", 32'(get_pready(d)), 32'd0);
    if (!keep) begin
      psel_a = 1'b0;
      psel_b = 1'b0;
      penable = 1'b0;
      @(posedge pclk); #1;
    end
  endtask

  task automatic run_checked(input int d, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb, input bit keep,
                             input string tag);
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    int          w;
    model_xfer(d, wr, addr, data, strb, exp_rd, exp_er);
    xfer(d, wr, addr, data, strb, keep, rd, er, w);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(er), 32'(exp_er));
    check({tag, "_waits"}, 32'(w), (d == 0) ? 32'd1 : 32'd4);
  endtask

  task automatic apply_reset();
    presetn = 1'b0;
    psel_a = 1'b0;
    psel_b = 1'b0;
    penable = 1'b0;
    model_clear();
    @(posedge pclk); @(posedge pclk); #1;
    presetn = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er, dummy_er;
    int          w;
    logic [31:0] dummy_rd;

    presetn = 1'b0;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
    model_clear();
    @(posedge pclk); #1;
    check("rst_pready_a", 32'(pready_a), 32'd0);
    check("rst_pslverr_a", 32'(pslverr_a), 32'd0);
    check("rst_prdata_a", prdata_a, 32'h0);
    check("rst_pready_b", 32'(pready_b), 32'd0);
    check("rst_pslverr_b", 32'(pslverr_b), 32'd0);
    check("rst_prdata_b", prdata_b, 32'h0);
    @(posedge pclk); #1;
    presetn = 1'b1;

    // Directed vectors: {dut, wr, addr, data, strb, keep, exp_rdata, exp_err}
    vecs.push_back('{0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h04, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h08, 32'h11223344, 4'hF, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h08, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h08, 32'h0,        4'h0, 1'b0, 32'h11BB33DD, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h03, 32'h0,        4'h0, 1'b0, 32'h0, 1'b1});
    vecs.push_back('{0, 1'b0, 32'h40, 32'h0,        4'h0, 1'b0, 32'h0, 1'b1});
    vecs.push_back('{0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 1'b1});
    vecs.push_back('{0, 1'b1, 32'h04, 32'h00000000, 4'h0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h04, 32'h0,        4'hF, 1'b0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h3C, 32'h0BADF00D, 4'hF, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h3C, 32'h0,        4'h0, 1'b0, 32'h0BADF00D, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h08, 32'h55667788, 4'hF, 1'b1, 32'h0, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h08, 32'h0,        4'h0, 1'b0, 32'h55667788, 1'b0});
    vecs.push_back('{1, 1'b1, 32'h00, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{1, 1'b1, 32'h04, 32'h12345678, 4'hF, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{1, 1'b0, 32'h04, 32'h0,        4'h0, 1'b0, 32'h12345678, 1'b0});
    vecs.push_back('{1, 1'b0, 32'h00, 32'h0,        4'h0, 1'b1, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{1, 1'b0, 32'h04, 32'h0,        4'h0, 1'b0, 32'h12345678, 1'b0});
    vecs.push_back('{1, 1'b0, 32'h3E, 32'h0,        4'h0, 1'b0, 32'h0, 1'b1});
    vecs.push_back('{1, 1'b0, 32'h44, 32'h0,        4'h0, 1'b0, 32'h0, 1'b1});

    foreach (vecs[i]) begin
      model_xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, dummy_rd, dummy_er);
      xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].keep, rd, er, w);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_waits", i), 32'(w), (vecs[i].d == 0) ? 32'd1 : 32'd4);
    end

    // Every word after the out-of-range write must match the reference
    for (int i = 0; i < 16; i++) run_checked(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, 1'b0, "sweep_a");

    // Abort on the zero-wait instance: psel low during the access phase
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h4; pwdata = 32'h5A5A5A5A; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1; psel_a = 1'b0;
    @(negedge pclk);
    check("abort_a_wait", 32'(pready_a), 32'd0);
    @(negedge pclk);
    check("abort_a_pready", 32'(pready_a), 32'd1);
    check("abort_a_pslverr", 32'(pslverr_a), 32'd1);
    check("abort_a_prdata", prdata_a, 32'h0);
    @(posedge pclk); #1;
    penable = 1'b0;
    @(posedge pclk); #1;
    run_checked(0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, "abort_a_read");

    // Abort on the three-wait instance: psel drops in the second access cycle
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h4; pwdata = 32'h5A5A5A5A; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel_b = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    check("abort_b_pready", 32'(pready_b), 32'd1);
    check("abort_b_pslverr", 32'(pslverr_b), 32'd1);
    @(posedge pclk); #1;
    penable = 1'b0;
    @(posedge pclk); #1;
    run_checked(1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, "abort_b_read");

    // Random transfers against the reference model
    for (int k = 0; k < 150; k++) begin
      int d, sel, idx;
      logic wr;
      logic [31:0] addr;
      bit keep;
      d = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      idx = int'($urandom_range(0, 15));
      wr = 1'($urandom_range(0, 1));
      if (sel < 8) addr = 32'(idx * 4);
      else if (sel == 8) addr = 32'(idx * 4) + 32'($urandom_range(1, 3));
      else addr = 32'h40 + 32'($urandom_range(0, 63) * 4);
      keep = (k != 149) && ($urandom_range(0, 3) == 0);
      run_checked(d, wr, addr, $urandom, 4'($urandom_range(0, 15)), keep, "rand");
    end
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;

    // Reset while the zero-wait instance is driving pready
    run_checked(0, 1'b1, 32'hC, 32'h77778888, 4'hF, 1'b0, "pre_rst_a");
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'hC; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    check("rst_a_pre_pready", 32'(pready_a), 32'd1);
    presetn = 1'b0;
    #1;
    check("rst_a_pready", 32'(pready_a), 32'd0);
    check("rst_a_pslverr", 32'(pslverr_a), 32'd0);
    apply_reset();

    // Reset while the three-wait instance sits in its access wait cycles
    run_checked(1, 1'b1, 32'hC, 32'h12345678, 4'hF, 1'b0, "pre_rst_b");
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'hC; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); @(posedge pclk); #1;
    presetn = 1'b0;
    #1;
    check("rst_b_pready", 32'(pready_b), 32'd0);
    check("rst_b_pslverr", 32'(pslverr_b), 32'd0);
    check("rst_b_prdata", prdata_b, 32'h0);
    apply_reset();

    run_checked(1, 1'b0, 32'hC, 32'h0, 4'h0, 1'b0, "post_rst_b");
    run_checked(0, 1'b0, 32'hC, 32'h0, 4'h0, 1'b0, "post_rst_a");
    run_checked(0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, "post_rst_a4");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
